// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared opcodes, NOP encoding and fetch queue entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Queue entries are laid out for a 32-bit datapath.
    localparam int unsigned c_xlen = 32;

    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;

    localparam logic [c_xlen-1:0] c_nop_instr = 32'h0000_0013;

    typedef struct packed {
        logic [c_xlen-1:0] instr;
        logic [c_xlen-1:0] pc;
        logic [c_xlen-1:0] imm;
        logic [c_xlen-1:0] pc_save;
        logic              pred;
    } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_predecoder.sv
`default_nettype none
// ============================================================================
// Module   : fetch_predecoder
// Purpose  : Combinational control-flow classification, immediate extraction
//            and static (JAL-taken / BTFN) prediction of a fetched word.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_predecoder
    import fetch_pkg::*;
#(
    parameter int unsigned SIZE    = c_xlen,
    parameter bit          BTFN_EN = 1'b1
) (
    input  logic [SIZE-1:0] instruction,
    output logic [SIZE-1:0] imm,
    output logic            is_jal,
    output logic            is_branch,
    output logic            is_jalr,
    output logic            pred_taken
);

    logic [6:0]      w_opcode;
    logic [SIZE-1:0] w_imm_i;
    logic [SIZE-1:0] w_imm_b;
    logic [SIZE-1:0] w_imm_j;

    assign w_opcode = instruction[6:0];

    assign w_imm_i = {{(SIZE-12){instruction[31]}}, instruction[31:20]};
    assign w_imm_b = {{(SIZE-13){instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
    assign w_imm_j = {{(SIZE-21){instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        is_jal     = 1'b0;
        is_branch  = 1'b0;
        is_jalr    = 1'b0;
        imm        = w_imm_i;
        pred_taken = 1'b0;
        case (w_opcode)
            c_op_jal: begin
                is_jal     = 1'b1;
                imm        = w_imm_j;
                pred_taken = 1'b1;
            end
            c_op_branch: begin
                is_branch  = 1'b1;
                imm        = w_imm_b;
                // Backward (negative offset) branches are predicted taken.
                pred_taken = BTFN_EN & w_imm_b[SIZE-1];
            end
            c_op_jalr: begin
                is_jalr = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_stage
// Purpose  : Fetch stage with PC register, static prediction and a DEPTH-entry
//            queue decoupling instruction memory from a stallable decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     SIZE     = c_xlen,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [SIZE-1:0] RESET_PC = '0,
    parameter bit              BTFN_EN  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [SIZE-1:0]            imem_addr_o,
    output logic                       imem_req_o,
    input  logic [SIZE-1:0]            instruction_i,
    input  logic                       misprediction,
    input  logic [SIZE-1:0]            correct_pc,
    input  logic                       dec_ready_i,
    output logic                       dec_valid_o,
    output logic [SIZE-1:0]            instruction_o,
    output logic [SIZE-1:0]            pc_o,
    output logic [SIZE-1:0]            imm_o,
    output logic [SIZE-1:0]            pc_save_o,
    output logic                       branch_prediction_o,
    output logic [$clog2(DEPTH+1)-1:0] fq_count_o
);

    localparam int unsigned         c_ptr_w = $clog2(DEPTH);
    localparam int unsigned         c_cnt_w = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(DEPTH);

    logic [SIZE-1:0]    r_pc;
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;
    fq_entry_t          r_mem [DEPTH];

    logic [SIZE-1:0] w_imm;
    logic            w_is_jal;
    logic            w_is_branch;
    logic            w_is_jalr;
    logic            w_pred_taken;
    logic            w_take;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic [SIZE-1:0] w_pc_plus4;
    logic [SIZE-1:0] w_pc_next;
    fq_entry_t       w_new_entry;
    fq_entry_t       w_head;

    fetch_predecoder #(
        .SIZE    (SIZE),
        .BTFN_EN (BTFN_EN)
    ) u_predecoder (
        .instruction (instruction_i),
        .imm         (w_imm),
        .is_jal      (w_is_jal),
        .is_branch   (w_is_branch),
        .is_jalr     (w_is_jalr),
        .pred_taken  (w_pred_taken)
    );

    // Only direct control flow can redirect fetch; JALR targets are unknown here.
    assign w_take = w_pred_taken & (w_is_jal | w_is_branch) & ~w_is_jalr;

    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & dec_ready_i;
    assign w_push     = ~misprediction & ((r_count < c_depth) | w_pop);
    assign w_pc_plus4 = r_pc + SIZE'(4);

    always_comb begin
        w_pc_next = r_pc;
        if (misprediction) begin
            w_pc_next = correct_pc;
        end else if (w_push) begin
            w_pc_next = w_take ? (r_pc + w_imm) : w_pc_plus4;
        end
    end

    always_comb begin
        w_new_entry.instr   = instruction_i;
        w_new_entry.pc      = r_pc;
        w_new_entry.imm     = w_imm;
        w_new_entry.pc_save = w_pc_plus4;
        w_new_entry.pred    = w_take;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (misprediction) begin
            r_pc    <= w_pc_next;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_wptr  <= r_wptr + c_ptr_w'(w_push);
            r_rptr  <= r_rptr + c_ptr_w'(w_pop);
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    // Payload storage needs no reset: occupancy alone qualifies the head.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wptr] <= w_new_entry;
        end
    end

    assign w_head = r_mem[r_rptr];

    always_comb begin
        instruction_o       = c_nop_instr;
        pc_o                = '0;
        imm_o               = '0;
        pc_save_o           = '0;
        branch_prediction_o = 1'b0;
        if (w_valid) begin
            instruction_o       = w_head.instr;
            pc_o                = w_head.pc;
            imm_o               = w_head.imm;
            pc_save_o           = w_head.pc_save;
            branch_prediction_o = w_head.pred;
        end
    end

    assign imem_addr_o = r_pc;
    assign imem_req_o  = w_push;
    assign dec_valid_o = w_valid;
    assign fq_count_o  = r_count;

endmodule
`default_nettype wire
